decoder_seq: RTL and testbench

DECODER_SEQ -- requirements
Module: decoder_seq

---
 rtl/decoder_pkg.sv | 21 ++
 rtl/decoder_seq_if.sv | 26 ++
 rtl/dwell_timer.sv | 27 ++
 rtl/decoder_seq.sv | 94 +++++++++
 tb/tb_decoder_seq.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared state type and decode helper for the decoder sequencer
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam int unsigned MAX_OUT_W = 256;

  // Returns all-zero when index is outside width, so callers truncate safely.
  function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned index,
                                                   input int unsigned width);
    logic [MAX_OUT_W-1:0] v;
    v = MAX_OUT_W'(1) << index;
    if (index >= width) v = '0;
    return v;
  endfunction

endpackage

// File: rtl/decoder_seq_if.sv
// rtl/decoder_seq_if.sv - control and decode-output bundle of the decoder sequencer
interface decoder_seq_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 2**SEL_W;

  logic             en;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] y;
  logic             out_valid;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (
    output en, mode, in_valid, sel,
    input  in_ready, y, out_valid, idx, wrap
  );

  modport slave (
    input  en, mode, in_valid, sel,
    output in_ready, y, out_valid, idx, wrap
  );
endinterface

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - loadable down-counter timing how long a scan line stays active
module dwell_timer #(
  parameter  int DWELL = 1,
  localparam int CNT_W = $clog2(DWELL + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  output logic expire
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (load)
      cnt <= CNT_W'(DWELL);
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  // Last cycle of the dwell window; the owner reloads on this cycle.
  assign expire = (cnt == CNT_W'(1));
endmodule

// File: rtl/decoder_seq.sv
// rtl/decoder_seq.sv - registered one-hot decoder with direct-decode and auto-scan modes
module decoder_seq
  import decoder_pkg::*;
#(
  parameter  int SEL_W      = 3,
  parameter  int DWELL      = 1,
  parameter  bit ACTIVE_LOW = 1'b0,
  localparam int OUT_W      = 2**SEL_W
) (
  input  logic         clk,
  input  logic         rst,
  decoder_seq_if.slave bus
);
  localparam logic [OUT_W-1:0] Y_MASK = {OUT_W{ACTIVE_LOW}};

  state_t           state;
  state_t           target;
  logic [OUT_W-1:0] y_q;
  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_next;
  logic             out_valid_q;
  logic             wrap_q;
  logic             expire;
  logic             tmr_clear;
  logic             tmr_load;

  always_comb begin
    target = IDLE;
    if (bus.en) target = bus.mode ? SCAN : DIRECT;
  end

  assign idx_next  = idx_q + SEL_W'(1);
  assign tmr_clear = (target != SCAN);
  // Reload on scan entry (from IDLE or a frozen DIRECT index) and on every step.
  assign tmr_load  = (target == SCAN) && ((state != SCAN) || expire);

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .load   (tmr_load),
    .expire (expire)
  );

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] i);
    return OUT_W'(onehot(32'(i), OUT_W)) ^ Y_MASK;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      y_q         <= Y_MASK;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state       <= target;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      case (target)
        IDLE: begin
          y_q   <= Y_MASK;
          idx_q <= '0;
        end
        DIRECT: begin
          if (state == DIRECT && bus.in_valid) begin
            y_q         <= decode(bus.sel);
            idx_q       <= bus.sel;
            out_valid_q <= 1'b1;
          end
        end
        SCAN: begin
          if (state == IDLE) begin
            y_q         <= decode('0);
            idx_q       <= '0;
            out_valid_q <= 1'b1;
          end else if (state == SCAN && expire) begin
            y_q         <= decode(idx_next);
            idx_q       <= idx_next;
            out_valid_q <= 1'b1;
            wrap_q      <= (idx_q == '1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == DIRECT) && !rst;
  assign bus.y         = y_q;
  assign bus.idx       = idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_decoder_seq.sv
// tb/tb_decoder_seq.sv - directed and randomized checks of decoder_seq against a behavioural model
`timescale 1ns/1ps
module tb_decoder_seq;
  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       clk_on = 1'b1;
  logic       en     = 1'b0;
  logic       mode   = 1'b0;
  logic       iv     = 1'b0;
  logic [2:0] sel    = 3'd0;
  int errors = 0;
  int checks = 0;

  always #5 if (clk_on) clk = ~clk;

  decoder_seq_if #(.SEL_W(3)) bus0 ();
  decoder_seq_if #(.SEL_W(3)) bus1 ();
  decoder_seq_if #(.SEL_W(3)) bus2 ();

  assign bus0.en = en;  assign bus0.mode = mode;  assign bus0.in_valid = iv;  assign bus0.sel = sel;
  assign bus1.en = en;  assign bus1.mode = mode;  assign bus1.in_valid = iv;  assign bus1.sel = sel;
  assign bus2.en = en;  assign bus2.mode = mode;  assign bus2.in_valid = iv;  assign bus2.sel = sel;

  decoder_seq #(.SEL_W(3), .DWELL(2), .ACTIVE_LOW(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  decoder_seq #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  decoder_seq #(.SEL_W(3), .DWELL(3), .ACTIVE_LOW(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  logic [7:0] y_o   [3];
  logic [2:0] idx_o [3];
  logic       ov_o  [3];
  logic       wr_o  [3];
  logic       rdy_o [3];

  assign y_o[0] = bus0.y;  assign idx_o[0] = bus0.idx;  assign ov_o[0] = bus0.out_valid;
  assign wr_o[0] = bus0.wrap;  assign rdy_o[0] = bus0.in_ready;
  assign y_o[1] = bus1.y;  assign idx_o[1] = bus1.idx;  assign ov_o[1] = bus1.out_valid;
  assign wr_o[1] = bus1.wrap;  assign rdy_o[1] = bus1.in_ready;
  assign y_o[2] = bus2.y;  assign idx_o[2] = bus2.idx;  assign ov_o[2] = bus2.out_valid;
  assign wr_o[2] = bus2.wrap;  assign rdy_o[2] = bus2.in_ready;

  int dw [3] = '{2, 1, 3};
  bit al [3] = '{1'b0, 1'b1, 1'b0};

  // Model: mode 0 idle, 1 direct, 2 scan; age = cycles the current scan line has been shown.
  int m_st [3];
  int m_line [3];
  int m_age [3];
  bit m_lit [3];
  bit m_pv [3];
  bit m_pw [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0;  m_line[k] = 0;  m_age[k] = 0;
      m_lit[k] = 1'b0;  m_pv[k] = 1'b0;  m_pw[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      m_pv[k] = 1'b0;
      m_pw[k] = 1'b0;
      if (!en) begin
        m_st[k] = 0;  m_line[k] = 0;  m_lit[k] = 1'b0;  m_age[k] = 0;
      end else if (!mode) begin
        if (m_st[k] == 1 && iv) begin
          m_line[k] = int'(sel);  m_lit[k] = 1'b1;  m_pv[k] = 1'b1;
        end
        m_st[k] = 1;
        m_age[k] = 0;
      end else begin
        if (m_st[k] == 0) begin
          m_line[k] = 0;  m_lit[k] = 1'b1;  m_pv[k] = 1'b1;  m_age[k] = 1;
        end else if (m_st[k] == 1) begin
          m_age[k] = 1;
        end else if (m_age[k] == dw[k]) begin
          m_line[k] = (m_line[k] + 1) % 8;
          m_lit[k] = 1'b1;  m_pv[k] = 1'b1;
          m_pw[k] = (m_line[k] == 0);
          m_age[k] = 1;
        end else begin
          m_age[k]++;
        end
        m_st[k] = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] ey;
      ey = m_lit[k] ? 8'(1 << m_line[k]) : 8'h00;
      if (al[k]) ey = ~ey;
      chk($sformatf("y%0d", k), y_o[k], ey);
      chk($sformatf("idx%0d", k), 8'(idx_o[k]), 8'(m_line[k]));
      chk($sformatf("out_valid%0d", k), 8'(ov_o[k]), 8'(m_pv[k]));
      chk($sformatf("wrap%0d", k), 8'(wr_o[k]), 8'(m_pw[k]));
      chk($sformatf("in_ready%0d", k), 8'(rdy_o[k]), 8'(m_st[k] == 1 && !rst));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // direct decode of sel=5, hold, repeated identical sel
    en = 1'b1;  mode = 1'b0;  tick();
    iv = 1'b1;  sel = 3'd5;  tick();
    chk("direct_y", y_o[0], 8'h20);
    chk("direct_ov", 8'(ov_o[0]), 8'h01);
    iv = 1'b0;  tick();
    chk("direct_hold_ov", 8'(ov_o[0]), 8'h00);
    chk("direct_hold_y", y_o[0], 8'h20);
    iv = 1'b1;  repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      sel = i[2:0];
      tick();
    end

    // scan continuing from direct index, with in_valid/sel noise
    mode = 1'b1;  sel = 3'd6;
    repeat (20) tick();

    // scan from idle through a full wrap
    en = 1'b0;  iv = 1'b0;  tick();
    en = 1'b1;  tick();
    repeat (15) tick();
    chk("scan_last_y", y_o[0], 8'h80);
    tick();
    chk("scan_wrap_y", y_o[0], 8'h01);
    chk("scan_wrap", 8'(wr_o[0]), 8'h01);

    // freeze at idx 3 when switching to direct, then decode sel=7
    en = 1'b0;  tick();
    en = 1'b1;  tick();
    repeat (6) tick();
    chk("scan_idx3", 8'(idx_o[0]), 8'h03);
    mode = 1'b0;  tick();
    chk("freeze_y", y_o[0], 8'h08);
    chk("freeze_ready", 8'(rdy_o[0]), 8'h01);
    chk("freeze_ov", 8'(ov_o[0]), 8'h00);
    iv = 1'b1;  sel = 3'd7;  tick();
    chk("after_freeze_y", y_o[0], 8'h80);

    // active-low instance
    sel = 3'd0;  tick();
    chk("al_y", y_o[1], 8'hFE);
    en = 1'b0;  iv = 1'b0;  tick();
    chk("al_idle_y", y_o[1], 8'hFF);

    // asynchronous reset mid-scan with the clock stopped
    en = 1'b1;  mode = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    clk_on = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async_y", y_o[0], 8'h00);
    #3 rst = 1'b0;
    clk_on = 1'b1;
    tick();

    for (int n = 0; n < 400; n++) begin
      en   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 5) == 0) mode = ~mode;
      iv   = 1'($urandom_range(0, 1));
      sel  = 3'($urandom_range(0, 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
